// File: rtl/code_density_hist.sv
// Code-density histogram: bins ADC words into 2**WIDTH saturating counters with host readout.
// Optional automatic stop after N_SAMPLES accepted samples when HIST_AUTOSTOP_EN is defined.
module code_density_hist #(
  parameter int WIDTH     = 10,
  parameter int COUNT_W   = 24,
  parameter int N_SAMPLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               D_en,
  input  logic [WIDTH-1:0]   pdo,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               rd_en,
  input  logic [WIDTH-1:0]   rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               acq,
  output logic [COUNT_W-1:0] sample_count,
  output logic               sat
);

  localparam int DEPTH = 2 ** WIDTH;
  localparam logic [COUNT_W-1:0] MAX = '1;
`ifdef HIST_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACQ, S_DRAIN, S_HOLD} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     clr_addr;
  logic                 drain_cnt;
  logic                 accept, auto_hit, hold_full, flush, rd_fire;

  logic [COUNT_W-1:0]   mem [DEPTH];
  logic [COUNT_W-1:0]   ram_q;
  logic [WIDTH-1:0]     raddr, waddr;
  logic [COUNT_W-1:0]   wdata;
  logic                 we;

  logic                 s1_valid, s2_valid, s3_valid;
  logic [WIDTH-1:0]     s1_addr, s2_addr, s3_addr;
  logic [COUNT_W-1:0]   s2_data, s3_data;
  logic [COUNT_W-1:0]   fwd_val, inc_val;
  logic [COUNT_W-1:0]   rd_hold;

  assign accept    = (state == S_ACQ) && D_en && !clear;
  assign auto_hit  = AUTOSTOP && accept && (sample_count >= COUNT_W'(N_SAMPLES - 1));
  assign hold_full = AUTOSTOP && (sample_count >= COUNT_W'(N_SAMPLES));
  assign flush     = (state_next == S_CLEAR);
  assign rd_fire   = rd_en && ((state == S_IDLE) || (state == S_HOLD));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_CLEAR;
    else      state <= state_next;
  end

  // Next-state logic; clear outranks stop, which outranks start
  always_comb begin
    // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      S_CLEAR: if (&clr_addr) state_next = S_IDLE;
      S_IDLE:  if (clear) state_next = S_CLEAR;
               else if (start) state_next = S_ACQ;
      S_ACQ:   if (clear) state_next = S_CLEAR;
               else if (stop || auto_hit) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_next = S_HOLD;
      S_HOLD:  if (clear) state_next = S_CLEAR;
               else if (start && !hold_full) state_next = S_ACQ;
      default: state_next = S_CLEAR;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == S_CLEAR) || (state == S_DRAIN);
    acq  = (state == S_ACQ);
  end

  // Newest in-flight value for the bin in S1: pending write, then last write, then RAM
  always_comb begin
    if (s2_valid && (s2_addr == s1_addr))      fwd_val = s2_data;
    else if (s3_valid && (s3_addr == s1_addr)) fwd_val = s3_data;
    else                                       fwd_val = ram_q;
    inc_val = (fwd_val == MAX) ? MAX : fwd_val + 1'b1;
  end

  assign raddr = (state == S_ACQ) ? pdo : rd_addr;
  assign we    = (state == S_CLEAR) || s2_valid;
  assign waddr = (state == S_CLEAR) ? clr_addr : s2_addr;
  assign wdata = (state == S_CLEAR) ? '0 : s2_data;

  // NOTE: the histogram RAM has no reset; the mandatory CLEAR sweep initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ram_q <= mem[raddr];
  end

  // NOTE: all sequential state uses non-blocking assignments so stages see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_addr     <= '0;
      drain_cnt    <= 1'b0;
      sample_count <= '0;
      sat          <= 1'b0;
      rd_valid     <= 1'b0;
      rd_hold      <= '0;
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s3_valid     <= 1'b0;
      s1_addr      <= '0;
      s2_addr      <= '0;
      s3_addr      <= '0;
      s2_data      <= '0;
      s3_data      <= '0;
    end else begin
      clr_addr  <= (state == S_CLEAR) ? clr_addr + 1'b1 : '0;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      rd_valid  <= rd_fire;
      if (rd_valid) rd_hold <= ram_q;

      s1_valid <= accept;
      s1_addr  <= pdo;
      s2_valid <= s1_valid && !flush;
      s2_addr  <= s1_addr;
      s2_data  <= inc_val;
      s3_valid <= s2_valid && !flush;
      s3_addr  <= s2_addr;
      s3_data  <= s2_data;

      if (flush) begin
        sample_count <= '0;
        sat          <= 1'b0;
      end else begin
        if (accept && (sample_count != MAX)) sample_count <= sample_count + 1'b1;
        if (s1_valid && (inc_val == MAX))    sat <= 1'b1;
      end
    end
  end

  // Read data is live in the valid cycle and held afterwards
  assign rd_data = rd_valid ? ram_q : rd_hold;

endmodule
